// File: rtl/add_arbiter.sv
// add_arbiter: round-robin issue of add operations from several requesters
// to one adder; results routed back in issue order through a tag FIFO.
// Optional per-requester grant counters: ADD_ARBITER_GRANT_CNT_EN.
module add_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  add_valid_o,
  output logic [31:0]           add_a_o,
  output logic [31:0]           add_b_o,
  input  logic                  add_ready_i,
  input  logic                  add_valid_i,
  input  logic [31:0]           add_sum_i,
  input  logic                  add_carry_i,
  output logic                  add_ready_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic [31:0]           rsp_sum_o,
  output logic                  rsp_carry_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic                  err_o,
  output logic [NUM_REQ*16-1:0] grant_cnt_o
);

  localparam int TW = (NUM_REQ > 2) ? 2 : 1;
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  logic [TW-1:0]      last_q, last_d;
  logic [TW-1:0]      tag_q [DEPTH];
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0]      gidx;
  logic [TW-1:0]      head;
  logic               any_req;
  logic               full;
  logic               empty;
  logic               head_rdy;
  logic               push;
  logic               pop;

  // first valid requester after last, wrapping; lowest offset wins
  function automatic logic [TW-1:0] pick(
    input logic [TW-1:0]      last,
    input logic [NUM_REQ-1:0] v
  );
    int idx;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[idx]) pick = TW'(idx);
    end
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = tag_q[rd_q];

  // combinational issue path: grant, operand mux, ready
  always_comb begin
    any_req = |req_valid_i;
    gidx    = pick(last_q, req_valid_i);
    grant   = '0;
    add_a_o = '0;
    add_b_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (any_req && gidx == TW'(k)) begin
        grant[k] = 1'b1;
        add_a_o  = req_a_i[32*k +: 32];
        add_b_o  = req_b_i[32*k +: 32];
      end
    end
    add_valid_o = any_req & ~full;
    req_ready_o = grant & {NUM_REQ{add_ready_i & ~full}};
  end

  // result routing to the owner of the oldest in-flight tag
  always_comb begin
    rsp_valid_o = '0;
    head_rdy    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (head == TW'(k)) begin
        rsp_valid_o[k] = add_valid_i & ~empty;
        head_rdy       = rsp_ready_i[k];
      end
    end
    add_ready_o = ~empty & head_rdy;
  end

  assign rsp_sum_o   = add_sum_i;
  assign rsp_carry_o = add_carry_i;
  assign push        = add_valid_o & add_ready_i;
  assign pop         = add_valid_i & add_ready_o;
  assign err_o       = err_q;

  // next state of pointers, occupancy, priority and error flag
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    err_d  = err_q | (add_valid_i & empty);
    if (push) begin
      wr_d   = wr_q + 1'b1;
      last_d = gidx;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // control state registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= TW'(NUM_REQ - 1);
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  // tag storage written at the tail on each issue
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int d = 0; d < DEPTH; d++) tag_q[d] <= '0;
    end else if (push) begin
      tag_q[wr_q] <= gidx;
    end
  end

`ifdef ADD_ARBITER_GRANT_CNT_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] gcnt_d [NUM_REQ];

  // saturating issue count per requester
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      gcnt_d[k] = gcnt_q[k];
      if (push && gidx == TW'(k) && gcnt_q[k] != 16'hFFFF)
        gcnt_d[k] = gcnt_q[k] + 16'd1;
      grant_cnt_o[16*k +: 16] = gcnt_q[k];
    end
  end

  // counter registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= gcnt_d[k];
    end
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters; legal 2..4.
REQ-002 Parameter DEPTH, default 2, in-flight tag FIFO entries; legal 2 or 4.
REQ-003 Ports: one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  clock, all state on rising edge.
REQ-005 reset_ni  in  1  asynchronous active-low reset.
REQ-006 req_valid_i  in  NUM_REQ  per-requester operation valid.
REQ-007 req_a_i, req_b_i  in  NUM_REQ*32 each  packed operands; requester k at bits [32k+31:32k].
REQ-008 req_ready_o  out  NUM_REQ  per-requester accept.
REQ-009 add_valid_o, add_a_o[32], add_b_o[32]  out  issue port to the adder.
REQ-010 add_ready_i  in  1  adder accepts issue.
REQ-011 add_valid_i, add_sum_i[32], add_carry_i[1]  in  adder result port.
REQ-012 add_ready_o  out  1  result accept to adder.
REQ-013 rsp_valid_o  out  NUM_REQ  per-requester result valid; rsp_sum_o[32], rsp_carry_o[1] out, shared.
REQ-014 rsp_ready_i  in  NUM_REQ  per-requester result accept.
REQ-015 err_o  out  1  sticky protocol-error flag.
REQ-016 grant_cnt_o  out  NUM_REQ*16  per-requester issue counters.

Function
REQ-017 Issue path SHALL be combinational: zero added latency from request to add_valid_o.
REQ-018 Grant SHALL be round-robin: first asserted req_valid_i searching from (last_ptr+1) mod NUM_REQ upward.
REQ-019 add_valid_o SHALL equal (any req_valid_i) AND NOT fifo_full; add_a_o/add_b_o SHALL carry granted requester's operands, zero when no grant.
REQ-020 req_ready_o[k] SHALL equal grant[k] AND add_ready_i AND NOT fifo_full; all others 0.
REQ-021 On issue handshake (add_valid_o & add_ready_i) the granted index SHALL be pushed to the tag FIFO and last_ptr SHALL update to it; otherwise last_ptr holds.
REQ-022 FIFO full SHALL block issue even if a pop occurs in the same cycle.
REQ-023 rsp_valid_o[k] SHALL equal add_valid_i AND fifo non-empty AND head tag==k; rsp_sum_o/rsp_carry_o SHALL pass add_sum_i/add_carry_i.
REQ-024 add_ready_o SHALL equal fifo non-empty AND rsp_ready_i[head tag].
REQ-025 On result handshake (add_valid_i & add_ready_o) head tag SHALL be popped; simultaneous push and pop leaves occupancy unchanged.
REQ-026 Results SHALL be routed strictly in issue order; back-pressure from the head owner stalls all results.
REQ-027 add_valid_i high with FIFO empty SHALL set err_o next edge; add_ready_o stays 0; err_o clears only on reset.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter range 0..DEPTH.

Reset
REQ-029 reset_ni low SHALL immediately clear FIFO (empty), err_o=0, grant_cnt_o=0, last_ptr=NUM_REQ-1 so requester 0 has first priority.
REQ-030 Outputs during reset: add_valid_o=(any req_valid_i), req_ready_o per REQ-020, add_ready_o=0, rsp_valid_o=0.
REQ-031 Reset mid-operation SHALL discard in-flight tags; a later adder result then sets err_o per REQ-027.

Configuration
REQ-032 Macro ADD_ARBITER_GRANT_CNT_EN defined: grant_cnt_o[k] SHALL increment on each issue handshake of requester k, saturating at 16'hFFFF.
REQ-033 Macro undefined: counters SHALL not be built; grant_cnt_o tied to zero.

Verification
REQ-034 Req0 and req1 valid continuously, add_ready_i=1, results returned 1 cycle later -> grants alternate 0,1,0,1, first grant 0; each result routed to its issuer.
REQ-035 DEPTH=2, adder never returns results, both requesting -> exactly 2 issues, then add_valid_o=0 and req_ready_o=0 until a pop.
REQ-036 Issue req0 a=32'hFFFF_FFFF b=1, then req1 a=2 b=3; adder returns {0,carry=1} then {5,0} -> rsp_valid_o[0] with sum 0 carry 1, then rsp_valid_o[1] with sum 5.
REQ-037 rsp_ready_i[0]=0 while head tag=0 -> add_ready_o=0, tag-1 result held behind it; release -> both drain in order.
REQ-038 add_valid_i=1 with empty FIFO -> err_o=1 next cycle, stays 1 until reset_ni low.
REQ-039 With ADD_ARBITER_GRANT_CNT_EN: 3 issues by req1 -> grant_cnt_o[31:16]=3; reset_ni pulse mid-stream -> counters 0, FIFO empty, next grant to requester 0.
